sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
- REQ-001: Parameter ADDR_W, default 8, SHALL set the sprite pixel address width (16x16 sprite = 256 entries).
- REQ-002: Parameter DATA_W, default 24, SHALL set the RGB pixel data width.
- REQ-003: Clk  input  1  SHALL be the single clock (50 MHz system clock).
- REQ-004: Reset_n  input  1  SHALL be the asynchronous, active-low reset.
- REQ-005: en  input  1  SHALL enable new grants when high.
- REQ-006: req0_valid, req1_valid  input  1 each  SHALL flag a pending pixel fetch from character 0 / character 1.
- REQ-007: req0_addr, req1_addr  input  ADDR_W each  SHALL carry the sprite pixel address.
- REQ-008: req0_face, req1_face  input  1 each  SHALL select the facing bank (0 = left, 1 = right).
- REQ-009: req0_ready, req1_ready  output  1 each  SHALL indicate that the request is accepted this cycle.
- REQ-010: rom_en  output  1  SHALL be the ROM read strobe.
- REQ-011: rom_addr  output  ADDR_W+1  SHALL be {face, addr} of the granted request.
- REQ-012: rom_data  input  DATA_W  SHALL be the synchronous ROM output, valid exactly 1 cycle after rom_en.
- REQ-013: rsp0_valid, rsp1_valid  output  1 each  SHALL pulse when the corresponding rsp data is valid.
- REQ-014: rsp_data  output  DATA_W  SHALL be the shared response data bus.
- REQ-015: busy  output  1  SHALL be high while a ROM read is in flight.

Function
- REQ-016: A request SHALL be accepted only in a cycle where reqN_valid and reqN_ready are both high.
- REQ-017: reqN_ready SHALL be a combinational function of en, the valid inputs, and the registered last_grant pointer.
- REQ-018: At most one reqN_ready SHALL be high in any cycle.
- REQ-019: With en=0, both ready signals and rom_en SHALL be 0.
- REQ-020: With en=1 and exactly one valid request, that requester SHALL be granted in the same cycle.
- REQ-021: With en=1 and both requests valid, the requester that is not last_grant SHALL be granted (round-robin).
- REQ-022: last_grant SHALL update on the clock edge after each accept, and only then.
- REQ-023: During an accept cycle, rom_en SHALL be 1 and rom_addr SHALL be {reqN_face, reqN_addr} of the winner; otherwise rom_en SHALL be 0 and rom_addr SHALL hold its previous value.
- REQ-024: The arbiter SHALL register the winner's tag (pend_valid, pend_id) on accept.
- REQ-025: One cycle after an accept, rsp<pend_id>_valid SHALL be 1 for exactly one cycle, with rsp_data = rom_data.
- REQ-026: In non-response cycles, both rsp valids SHALL be 0 and rsp_data SHALL hold its last value.
- REQ-027: Accept-to-response latency SHALL be exactly 1 cycle.
- REQ-028: Back-to-back accepts SHALL be allowed every cycle (throughput of 1 per cycle), and busy SHALL equal pend_valid.
- REQ-029: Deasserting en SHALL NOT cancel an in-flight read; its response SHALL still be delivered.
- REQ-030: A requester that drops valid before being granted SHALL lose its turn without changing last_grant.
- REQ-031: Continuous requests from both requesters SHALL be granted strictly alternately, so no requester waits more than 1 cycle.

Reset
- REQ-032: On Reset_n low, the block SHALL asynchronously clear last_grant to 1, pend_valid to 0, pend_id to 0, rom_addr to 0, and rsp_data to 0.
- REQ-033: During reset, all ready, rom_en, and rsp valid outputs SHALL be 0.
- REQ-034: Reset asserted with a read in flight SHALL drop that response, with no rsp valid pulse after reset release.
- REQ-035: The first contended grant after reset SHALL go to requester 0.

Verification
- REQ-036: Single requester: req0_valid=1, addr=0x21, face=1, en=1 -> same cycle req0_ready=1, rom_addr=0x121, rom_en=1; next cycle rsp0_valid=1, rsp_data=ROM[0x121].
- REQ-037: Contention after reset: both valid for 4 cycles (addr0=0x10, addr1=0x20) -> grants 0,1,0,1, and rsp pulses 0,1,0,1 lagging by 1 cycle.
- REQ-038: en gating: en=0 with both valid for 3 cycles -> no ready, no rom_en; en rises -> requester 0 granted immediately.
- REQ-039: In-flight over en drop: accept req1 then en=0 next cycle -> rsp1_valid still pulses once and busy falls.
- REQ-040: Reset mid-read: accept req0, then assert Reset_n low before the next edge -> no rsp0_valid, all outputs 0, last_grant=1.
- REQ-041: Withdrawn request: req1 valid while req0 holds grant, then req1 drops -> last_grant unchanged, and no rsp1 pulse.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Two-requester round-robin arbiter in front of a shared synchronous sprite ROM.
// Grants are combinational, and each response comes back exactly one cycle after its accept.
module sprite_rom_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 24
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              en,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic              req0_face,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic              req1_face,
   output logic              req0_ready,
   output logic              req1_ready,
   output logic              rom_en,
   output logic [ADDR_W:0]   rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              rsp0_valid,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy
);

   // Handshake: a request is accepted in a cycle where reqN_valid && reqN_ready.
   // Ready never waits on ready, so a requester may drop valid at any time before acceptance.
   logic              r_last_grant;
   logic              r_pend_valid;
   logic              r_pend_id;
   logic [ADDR_W:0]   r_rom_addr;
   logic [DATA_W-1:0] r_rsp_data;

   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_accept;
   logic [ADDR_W:0]   w_win_addr;

   // Under contention, the requester that was not granted last goes first.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (Reset_n && en) begin
         if (req0_valid && (!req1_valid || r_last_grant)) begin
            w_gnt0 = 1'b1;
         end else if (req1_valid) begin
            w_gnt1 = 1'b1;
         end
      end
   end

   assign w_accept   = w_gnt0 | w_gnt1;
   assign w_win_addr = w_gnt1 ? {req1_face, req1_addr} : {req0_face, req0_addr};

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_last_grant <= 1'b1;
         r_pend_valid <= 1'b0;
         r_pend_id    <= 1'b0;
         r_rom_addr   <= '0;
         r_rsp_data   <= '0;
      end else begin
         r_pend_valid <= w_accept;
         if (w_accept) begin
            r_last_grant <= w_gnt1;
            r_pend_id    <= w_gnt1;
            r_rom_addr   <= w_win_addr;
         end
         if (r_pend_valid) begin
            r_rsp_data <= rom_data;
         end
      end
   end

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;
   assign rom_en     = w_accept;
   assign rom_addr   = w_accept ? w_win_addr : r_rom_addr;

   // ROM data lands in the cycle after the accept, so it passes straight through and is held afterwards.
   assign rsp0_valid = r_pend_valid & ~r_pend_id;
   assign rsp1_valid = r_pend_valid & r_pend_id;
   assign rsp_data   = r_pend_valid ? rom_data : r_rsp_data;
   assign busy       = r_pend_valid;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a behavioural ROM and queue-based grant/response checking.
module tb_sprite_rom_arbiter;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        en = 1'b0;
   logic        req0_valid = 1'b0;
   logic [7:0]  req0_addr = '0;
   logic        req0_face = 1'b0;
   logic        req1_valid = 1'b0;
   logic [7:0]  req1_addr = '0;
   logic        req1_face = 1'b0;
   logic        req0_ready;
   logic        req1_ready;
   logic        rom_en;
   logic [8:0]  rom_addr;
   logic [23:0] rom_data = '0;
   logic        rsp0_valid;
   logic        rsp1_valid;
   logic [23:0] rsp_data;
   logic        busy;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] cyc = '0;

   // grant entry {cycle, {ready1,ready0}, rom_addr}; response entry {cycle, {rsp1,rsp0}, data}
   logic [26:0] gnt_q[$];
   logic [41:0] exp_q[$];

   sprite_rom_arbiter #(.ADDR_W(8), .DATA_W(24)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .en(en),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_face(req0_face),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_face(req1_face),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp_data(rsp_data), .busy(busy)
   );

   // ---------------- clock / reset, ROM model ----------------
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 16'd1;

   function automatic logic [23:0] rom_f(input logic [8:0] a);
      return {a[7:0], 7'h35, a};
   endfunction

   always @(posedge Clk) if (rom_en) rom_data <= rom_f(rom_addr);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   // g: 0 = no grant expected, 1 = requester 0, 2 = requester 1
   task automatic apply(input logic e, input logic v0, input logic [7:0] a0, input logic f0,
                        input logic v1, input logic [7:0] a1, input logic f1,
                        input int g, input bit rsp_expected = 1'b1);
      logic [8:0] ea;
      @(negedge Clk);
      en = e; req0_valid = v0; req0_addr = a0; req0_face = f0;
      req1_valid = v1; req1_addr = a1; req1_face = f1;
      if (g != 0) begin
         ea = (g == 1) ? {f0, a0} : {f1, a1};
         gnt_q.push_back({cyc, (g == 2), (g == 1), ea});
         if (rsp_expected) exp_q.push_back({cyc + 16'd1, (g == 2), (g == 1), rom_f(ea)});
      end
   endtask

   task automatic idle();
      apply(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, {req1_ready, req0_ready}, 2'b00);
      chk({tag, "_rom_en"}, rom_en, 1'b0);
      chk({tag, "_rsp_valid"}, {rsp1_valid, rsp0_valid}, 2'b00);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_rom_addr"}, rom_addr, 9'h000);
      chk({tag, "_rsp_data"}, rsp_data, 24'h0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [8:0]  last_addr = '0;
   logic [23:0] last_data = '0;

   always @(negedge Clk) begin
      #3;
      if (!Reset_n) begin
         last_addr = '0;
         last_data = '0;
      end else begin
         while (gnt_q.size() > 0 && gnt_q[0][26:11] < cyc) begin
            chk("missing_grant", 1'b0, 1'b1);
            void'(gnt_q.pop_front());
         end
         while (exp_q.size() > 0 && exp_q[0][41:26] < cyc) begin
            chk("missing_rsp", 1'b0, 1'b1);
            void'(exp_q.pop_front());
         end
         chk("ready_onehot", (req0_ready & req1_ready), 1'b0);
         chk("rom_en_vs_ready", rom_en, (req0_ready | req1_ready));
         chk("busy_vs_rsp", busy, (rsp0_valid | rsp1_valid));
         if (rom_en) begin
            if (gnt_q.size() == 0) chk("unexpected_grant", {req1_ready, req0_ready, rom_addr}, 11'h0);
            else begin
               chk("grant", {cyc, req1_ready, req0_ready, rom_addr}, gnt_q[0]);
               last_addr = gnt_q[0][8:0];
               void'(gnt_q.pop_front());
            end
         end else begin
            chk("rom_addr_hold", rom_addr, last_addr);
         end
         if (rsp0_valid || rsp1_valid) begin
            if (exp_q.size() == 0) chk("unexpected_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
            else begin
               chk("rsp", {cyc, rsp1_valid, rsp0_valid, rsp_data}, exp_q[0]);
               last_data = exp_q[0][23:0];
               void'(exp_q.pop_front());
            end
         end else begin
            chk("rsp_data_hold", rsp_data, last_data);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // requests pending while reset is held must see nothing
      en = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 8'h10; req1_addr = 8'h20;
      repeat (2) @(negedge Clk);
      #2 chk_all_zero("reset");
      @(negedge Clk);
      en = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      Reset_n = 1'b1;

      // contention after reset: 0,1,0,1
      apply(1, 1, 8'h10, 0, 1, 8'h20, 0, 1);
      apply(1, 1, 8'h10, 0, 1, 8'h20, 0, 2);
      apply(1, 1, 8'h10, 0, 1, 8'h20, 0, 1);
      apply(1, 1, 8'h10, 0, 1, 8'h20, 0, 2);
      idle();

      // en gating, then requester 0 wins as soon as en rises
      repeat (3) apply(0, 1, 8'h0A, 1, 1, 8'h0B, 0, 0);
      apply(1, 1, 8'h0A, 1, 1, 8'h0B, 0, 1);
      idle();

      // single requester: {face=1, addr=0x21} -> 0x121
      apply(1, 1, 8'h21, 1, 0, 8'h00, 0, 1);
      idle();

      // in-flight read survives en dropping
      apply(1, 0, 8'h00, 0, 1, 8'h33, 0, 2);
      apply(0, 0, 8'h00, 0, 1, 8'h33, 0, 0);
      apply(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);

      // withdrawn request: req1 loses its turn, last_grant stays on req0
      apply(1, 1, 8'h44, 0, 1, 8'h55, 1, 1);
      apply(1, 1, 8'h44, 0, 0, 8'h55, 1, 1);
      apply(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
      apply(1, 1, 8'h46, 0, 1, 8'h55, 1, 2);
      idle();

      // back-to-back accepts from alternating single requesters
      apply(1, 1, 8'h01, 0, 0, 8'h00, 0, 1);
      apply(1, 0, 8'h00, 0, 1, 8'h02, 1, 2);
      apply(1, 1, 8'h03, 1, 0, 8'h00, 0, 1);
      idle();

      // reset with a read in flight: response dropped, last_grant back to 1
      apply(1, 1, 8'h7E, 0, 0, 8'h00, 0, 1, 1'b0);
      #4 Reset_n = 1'b0;
      #2 chk_all_zero("reset_mid_read");
      @(negedge Clk);
      en = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      idle();
      apply(1, 1, 8'h11, 0, 1, 8'h22, 0, 1);
      idle();
      idle();
      repeat (2) @(negedge Clk);

      chk("gnt_q_empty", gnt_q.size(), 0);
      chk("exp_q_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule
